// File: rtl/uart_tx_sched.sv
// Round-robin byte arbiter + shared FIFO + frame sequencer feeding one UART TX core.
// Define UART_TX_SCHED_TAG_EN to send a tag frame 8'hA0|src whenever the source changes.
module uart_tx_sched #(
   parameter int NUM_REQ      = 4,
   parameter int FIFO_DEPTH   = 8,
   parameter int GAP_CYCLES   = 16,
   parameter int BUSY_TIMEOUT = 4096,
   localparam int SRC_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                        i_sys_clk,
   input  logic                        i_reset_n,
   input  logic [NUM_REQ-1:0]          i_req_valid,
   input  logic [8*NUM_REQ-1:0]        i_req_data,
   output logic [NUM_REQ-1:0]          o_req_ready,
   output logic                        o_tx_start,
   output logic [7:0]                  o_tx_data,
   input  logic                        i_tx_busy,
   input  logic                        i_tx_done,
   output logic [SRC_W-1:0]            o_tx_src,
   output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
   output logic                        o_timeout,
   output logic                        o_idle
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int ENT_W = SRC_W + 8;
   localparam int SW1   = SRC_W + 1;
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_LOAD      = 3'd1;
   localparam logic [2:0] ST_START     = 3'd2;
   localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
   localparam logic [2:0] ST_WAIT_DONE = 3'd4;
   localparam logic [2:0] ST_GAP       = 3'd5;
   localparam logic [2:0] ST_AFTER     = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

`ifdef UART_TX_SCHED_TAG_EN
   localparam logic [7:0] TAG_BASE = 8'hA0;
`endif

   // arbiter
   logic [SRC_W-1:0] rr_ptr_reg;
   logic [SRC_W-1:0] grant_id;
   logic             grant_any;
   logic [SW1-1:0]   arb_sum;
   logic [SRC_W-1:0] arb_idx;
   logic             active_reg;
   logic             accept_en;
   logic             push;
   logic [7:0]       push_data;

   // fifo
   logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0]   wr_ptr_reg;
   logic [PTR_W:0]   rd_ptr_reg;
   logic             fifo_empty;
   logic             fifo_full;
   logic [ENT_W-1:0] head_ent;
   logic [SRC_W-1:0] head_src;
   logic [7:0]       head_data;
   logic             pop;

   // sequencer
   logic [2:0]       state_reg, state_next;
   logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
   logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
   logic             timeout_reg, timeout_next;
   logic [7:0]       tx_data_reg, tx_data_next;
   logic [SRC_W-1:0] tx_src_reg, tx_src_next;
`ifdef UART_TX_SCHED_TAG_EN
   logic [SRC_W-1:0] last_src_reg, last_src_next;
   logic             last_vld_reg, last_vld_next;
`endif

   always_comb begin
      grant_id  = '0;
      grant_any = 1'b0;
      arb_sum   = '0;
      arb_idx   = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         arb_sum = {1'b0, rr_ptr_reg} + SW1'(off);
         if (arb_sum >= SW1'(NUM_REQ)) begin
            arb_sum = arb_sum - SW1'(NUM_REQ);
         end
         arb_idx = arb_sum[SRC_W-1:0];
         if (!grant_any && i_req_valid[arb_idx]) begin
            grant_any = 1'b1;
            grant_id  = arb_idx;
         end
      end
   end

   // active_reg keeps ready low while reset is held and for the first cycle after it
   assign accept_en = active_reg && !fifo_full;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
         assign o_req_ready[gi] = accept_en && grant_any && (grant_id == SRC_W'(gi));
      end
   endgenerate

   assign push      = |(i_req_valid & o_req_ready);
   assign push_data = i_req_data[{grant_id, 3'b000} +: 8];

   assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
   assign fifo_full  = (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]) &&
                       (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]);
   assign head_ent   = fifo_mem[rd_ptr_reg[PTR_W-1:0]];
   assign head_src   = head_ent[ENT_W-1:8];
   assign head_data  = head_ent[7:0];

   always_ff @(posedge i_sys_clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= {grant_id, push_data};
      end
   end

   always_comb begin
      state_next   = state_reg;
      tmo_cnt_next = tmo_cnt_reg;
      gap_cnt_next = gap_cnt_reg;
      timeout_next = timeout_reg;
      tx_data_next = tx_data_reg;
      tx_src_next  = tx_src_reg;
      pop          = 1'b0;
`ifdef UART_TX_SCHED_TAG_EN
      last_src_next = last_src_reg;
      last_vld_next = last_vld_reg;
`endif
      case (state_reg)
         ST_IDLE: begin
            if (!fifo_empty) begin
               state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            tx_src_next = head_src;
`ifdef UART_TX_SCHED_TAG_EN
            // source change: send the tag now and leave the data byte queued for the next pass
            if (!last_vld_reg || (head_src != last_src_reg)) begin
               tx_data_next  = TAG_BASE | 8'(head_src);
               last_src_next = head_src;
               last_vld_next = 1'b1;
            end else begin
               tx_data_next = head_data;
               pop          = 1'b1;
            end
`else
            tx_data_next = head_data;
            pop          = 1'b1;
`endif
            state_next = ST_START;
         end
         ST_START: begin
            // counter holds cycles elapsed since the start pulse
            tmo_cnt_next = TMO_W'(1);
            state_next   = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (i_tx_busy) begin
               state_next = ST_WAIT_DONE;
            end else if (i_tx_done) begin
               state_next   = ST_AFTER;
               gap_cnt_next = '0;
            end else if (int'(tmo_cnt_reg) >= BUSY_TIMEOUT - 1) begin
               timeout_next = 1'b1;
               state_next   = ST_AFTER;
               gap_cnt_next = '0;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            if (i_tx_done) begin
               state_next   = ST_AFTER;
               gap_cnt_next = '0;
            end
         end
         ST_GAP: begin
            if (int'(gap_cnt_reg) >= GAP_CYCLES - 1) begin
               state_next = ST_IDLE;
            end else begin
               gap_cnt_next = gap_cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         active_reg  <= 1'b0;
         rr_ptr_reg  <= '0;
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         state_reg   <= ST_IDLE;
         tmo_cnt_reg <= '0;
         gap_cnt_reg <= '0;
         timeout_reg <= 1'b0;
         tx_data_reg <= '0;
         tx_src_reg  <= '0;
`ifdef UART_TX_SCHED_TAG_EN
         last_src_reg <= '0;
         last_vld_reg <= 1'b0;
`endif
      end else begin
         active_reg <= 1'b1;
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
            rr_ptr_reg <= (grant_id == SRC_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         state_reg   <= state_next;
         tmo_cnt_reg <= tmo_cnt_next;
         gap_cnt_reg <= gap_cnt_next;
         timeout_reg <= timeout_next;
         tx_data_reg <= tx_data_next;
         tx_src_reg  <= tx_src_next;
`ifdef UART_TX_SCHED_TAG_EN
         last_src_reg <= last_src_next;
         last_vld_reg <= last_vld_next;
`endif
      end
   end

   assign o_tx_start   = (state_reg == ST_START);
   assign o_tx_data    = tx_data_reg;
   assign o_tx_src     = tx_src_reg;
   assign o_fifo_level = wr_ptr_reg - rd_ptr_reg;
   assign o_timeout    = timeout_reg;
   assign o_idle       = fifo_empty && (state_reg == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a small behavioural TX core model.
// Build with UART_TX_SCHED_TAG_EN to run the tag-frame sequence instead of the default suite.
module tb_uart_tx_sched;

   localparam int GAP   = 16;
   localparam int TMO   = 4096;
   localparam int FRAME = 10;

   logic        clk;
   logic        rst_n;
   logic [3:0]  valid;
   logic [31:0] req_data;
   logic [3:0]  ready;
   logic        start;
   logic [7:0]  txd;
   logic        busy;
   logic        done;
   logic [1:0]  src;
   logic [3:0]  level;
   logic        tmo;
   logic        idle;

   uart_tx_sched #(
      .NUM_REQ(4), .FIFO_DEPTH(8), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(TMO)
   ) dut (
      .i_sys_clk(clk), .i_reset_n(rst_n),
      .i_req_valid(valid), .i_req_data(req_data), .o_req_ready(ready),
      .o_tx_start(start), .o_tx_data(txd), .i_tx_busy(busy), .i_tx_done(done),
      .o_tx_src(src), .o_fifo_level(level), .o_timeout(tmo), .o_idle(idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // TX core model: 0 normal frame, 1 hold busy until mode changes, 2 never raise busy
   int         tx_mode;
   int         start_cnt;
   int         frame_cnt;
   bit         tx_active;
   logic [7:0] cur_byte;
   logic [7:0] sent_data [$];
   int         sent_src [$];
   logic [7:0] exp_data [$];
   int         exp_src [$];

   initial begin
      busy = 1'b0;
      done = 1'b0;
      tx_active = 1'b0;
      frame_cnt = 0;
      forever begin
         @(negedge clk);
         done = 1'b0;
         if (!rst_n) begin
            busy = 1'b0;
            tx_active = 1'b0;
         end else if (start) begin
            sent_data.push_back(txd);
            sent_src.push_back(int'(src));
            start_cnt++;
            cur_byte = txd;
            $display("tx frame %0d: data=%02h src=%0d t=%0t", start_cnt, txd, src, $time);
            if (tx_mode != 2) begin
               busy = 1'b1;
               tx_active = 1'b1;
               frame_cnt = 0;
            end
         end else if (tx_active) begin
            frame_cnt++;
            if (frame_cnt >= FRAME && tx_mode != 1) begin
               busy = 1'b0;
               done = 1'b1;
               tx_active = 1'b0;
               check("data_stable", txd, cur_byte);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      valid = '0;
      repeat (2) tick();
      sent_data.delete();
      sent_src.delete();
      start_cnt = 0;
      rst_n = 1'b1;
      repeat (2) tick();
   endtask

   task automatic push(input int id, input logic [7:0] b);
      int n;
      n = 0;
      req_data[id*8 +: 8] = b;
      valid[id] = 1'b1;
      #1;
      while (!ready[id] && n < 200) begin
         tick();
         n++;
      end
      check("push_accept", ready[id], 1);
      tick();
      valid[id] = 1'b0;
   endtask

   task automatic wait_idle(input string nm, input int limit);
      int n;
      n = 0;
      while (!idle && n < limit) begin
         tick();
         n++;
      end
      check(nm, idle, 1);
   endtask

   task automatic exp_add(input logic [7:0] b, input int s);
      exp_data.push_back(b);
      exp_src.push_back(s);
   endtask

   task automatic check_sent(input string nm);
      check({nm, "_count"}, sent_data.size(), exp_data.size());
      for (int i = 0; i < exp_data.size() && i < sent_data.size(); i++) begin
         check({nm, "_data"}, sent_data[i], exp_data[i]);
         check({nm, "_src"}, sent_src[i], exp_src[i]);
      end
      exp_data.delete();
      exp_src.delete();
   endtask

   typedef struct {
      logic [3:0] valid;
      logic [3:0] exp_ready;
      logic [3:0] exp_level;
   } vec_t;

   vec_t vecs [11];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 500us");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int moved;

      // arbiter vectors with the TX core stalled; the first byte is popped into the sequencer
      vecs[0]  = '{4'b1111, 4'b0001, 4'd1};
      vecs[1]  = '{4'b1111, 4'b0010, 4'd2};
      vecs[2]  = '{4'b1111, 4'b0100, 4'd2};
      vecs[3]  = '{4'b0101, 4'b0001, 4'd3};
      vecs[4]  = '{4'b1100, 4'b0100, 4'd4};
      vecs[5]  = '{4'b0000, 4'b0000, 4'd4};
      vecs[6]  = '{4'b1000, 4'b1000, 4'd5};
      vecs[7]  = '{4'b0010, 4'b0010, 4'd6};
      vecs[8]  = '{4'b0011, 4'b0001, 4'd7};
      vecs[9]  = '{4'b1111, 4'b0010, 4'd8};
      vecs[10] = '{4'b1111, 4'b0000, 4'd8};

      tx_mode = 0;
      start_cnt = 0;
      req_data = '0;
      rst_n = 1'b0;
      valid = 4'hF;
      repeat (3) tick();
      check("rst_ready", ready, 0);
      check("rst_start", start, 0);
      check("rst_data", txd, 0);
      check("rst_src", src, 0);
      check("rst_level", level, 0);
      check("rst_timeout", tmo, 0);
      check("rst_idle", idle, 1);
      valid = '0;
      do_reset();

`ifdef UART_TX_SCHED_TAG_EN
      push(2, 8'h33);
      push(2, 8'h34);
      push(1, 8'h77);
      wait_idle("tag_idle", 1000);
      exp_add(8'hA2, 2); exp_add(8'h33, 2); exp_add(8'h34, 2);
      exp_add(8'hA1, 1); exp_add(8'h77, 1);
      check_sent("tag");
`else
      // single byte, gap timing
      push(0, 8'h55);
      n = 0;
      while (!start && n < 50) begin tick(); n++; end
      check("single_start", start, 1);
      check("single_data", txd, 8'h55);
      check("single_src", src, 0);
      n = 0;
      while (!done && n < 100) begin tick(); n++; end
      check("single_done", done, 1);
      n = 0;
      while (!idle && n < 100) begin tick(); n++; end
      check("single_gap_cycles", n, GAP);
      check("single_start_count", start_cnt, 1);
      check("single_data_held", txd, 8'h55);

      // continuous round robin
      do_reset();
      req_data = 32'h13121110;
      valid = 4'hF;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("rr_grant", ready, 1 << (i % 4));
         tick();
      end
      valid = '0;
      wait_idle("rr_idle", 1000);
      exp_add(8'h10, 0); exp_add(8'h11, 1); exp_add(8'h12, 2);
      exp_add(8'h13, 3); exp_add(8'h10, 0);
      check_sent("rr");

      // table: arbitration and fill while TX is stalled
      do_reset();
      tx_mode = 1;
      req_data = 32'h13121110;
      for (int i = 0; i < 11; i++) begin
         valid = vecs[i].valid;
         #1;
         check("vec_ready", ready, vecs[i].exp_ready);
         tick();
         check("vec_level", level, vecs[i].exp_level);
      end
      valid = 4'hF;
      tx_mode = 0;
      n = 0;
      while (!done && n < 50) begin tick(); n++; end
      check("full_first_done", done, 1);
      moved = 0;
      for (int k = 0; k < 30; k++) begin
         if (|(valid & ready)) moved++;
         tick();
      end
      check("full_one_accept", moved, 1);
      valid = '0;
      wait_idle("full_idle", 2000);
      exp_add(8'h10, 0); exp_add(8'h11, 1); exp_add(8'h12, 2); exp_add(8'h10, 0);
      exp_add(8'h12, 2); exp_add(8'h13, 3); exp_add(8'h11, 1); exp_add(8'h10, 0);
      exp_add(8'h11, 1); exp_add(8'h12, 2);
      check_sent("full");

      // busy never rises
      do_reset();
      tx_mode = 2;
      push(1, 8'hA5);
      push(2, 8'h5A);
      n = 0;
      while (!start && n < 50) begin tick(); n++; end
      check("tmo_start", start, 1);
      n = 0;
      while (!tmo && n < 5000) begin tick(); n++; end
      check("tmo_cycles", n, TMO);
      tx_mode = 0;
      wait_idle("tmo_idle", 500);
      check("tmo_sticky", tmo, 1);
      check("tmo_start_count", start_cnt, 2);
      exp_add(8'hA5, 1); exp_add(8'h5A, 2);
      check_sent("tmo");

      // reset in the middle of a frame
      do_reset();
      check("mid_tmo_cleared", tmo, 0);
      tx_mode = 1;
      push(3, 8'h3C);
      n = 0;
      while (!busy && n < 50) begin tick(); n++; end
      push(0, 8'h11);
      push(1, 8'h22);
      check("mid_level", level, 2);
      check("mid_data", txd, 8'h3C);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_level", level, 0);
      check("mid_rst_data", txd, 0);
      check("mid_rst_src", src, 0);
      check("mid_rst_idle", idle, 1);
      check("mid_rst_start", start, 0);
      repeat (2) tick();
      check("mid_rst_busy", busy, 0);
      tx_mode = 0;
      sent_data.delete();
      sent_src.delete();
      rst_n = 1'b1;
      tick();
      push(2, 8'h99);
      wait_idle("mid_idle", 500);
      exp_add(8'h99, 2);
      check_sent("mid");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
